// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, raster counters,
// sync/active decode, tile-grid board reads and read-latency-aligned strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned TILE_LOG2 = 4,
    parameter int unsigned GRID_COLS = 40,
    parameter int unsigned GRID_ROWS = 30,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pix_tick,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [ADDR_W-1:0]  raddr,
    output logic               re,
    output logic               updateoutput,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam int unsigned        DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic [31:0]        addr_full;
    logic               tile_aligned;
    logic               in_grid;
    logic [RD_LAT-1:0]  rd_pipe;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign pix_tick = en & ~reset & (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pix_tick) begin
            if (col == H_LAST) begin
                col <= '0;
                row <= (row == V_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Decoded straight from the counters so they move in the same cycle.
    assign hsync  = ((32'(col) >= HS_START) && (32'(col) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync  = ((32'(row) >= VS_START) && (32'(row) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    assign active = (32'(col) < H_ACTIVE) && (32'(row) < V_ACTIVE);

    assign tx           = col >> TILE_LOG2;
    assign ty           = row >> TILE_LOG2;
    assign addr_full    = 32'(ty) * GRID_COLS + 32'(tx);
    assign raddr        = ADDR_W'(addr_full);
    assign tile_aligned = (col[TILE_LOG2-1:0] == '0);
    assign in_grid      = (32'(tx) < GRID_COLS) && (32'(ty) < GRID_ROWS);

    // One read per tile column on every active line; off-grid tiles stay idle.
    assign re = pix_tick & active & tile_aligned & in_grid;

    // NOTE: the latency pipe is reset like any other state so no stale read
    // strobe survives a reset; it shifts every clk so reads drain while frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= RD_LAT'({rd_pipe, re});
        end
    end

    assign updateoutput = rd_pipe[RD_LAT-1];

    assign line_start  = pix_tick & (col == '0);
    assign frame_start = line_start & (row == '0);

endmodule
